iterative_shifter: RTL and testbench
====================================

# iterative_shifter

Parametrised multi-cycle shifter for the datapath, generalising the fixed shift-left-by-2 used for branch offsets. It performs logical left, logical right, arithmetic right and rotate-left by a run-time amount. It moves at most STEP bit positions per clock, trading latency for area. A start/busy/done handshake lets the control unit stall while an instruction-level shift (SLL/SRL/SRA/SLLV/…) completes.

## Interface
- N_BITS, 32, data width; power of two, ≥ 4
- STEP, 4, maximum bit positions shifted per clock; power of two, 1 ≤ STEP ≤ N_BITS
- SHAMT_W, $clog2(N_BITS), width of shift amount (derived, not overridden)

- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start_i  input  1  request; sampled only when busy_o = 0
- mode_i  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROTL
- shamt_i  input  SHAMT_W  shift amount, 0 … N_BITS-1
- data_i  input  N_BITS  operand
- busy_o  output  1  operation in progress; new start_i ignored
- done_o  output  1  one-cycle pulse, data_o valid
- data_o  output  N_BITS  result; held until next accepted start

## Operation
- States: IDLE, SHIFT, DONE.
- Accept: rising edge with start_i = 1 and state ∈ {IDLE, DONE}. Captures data_i into the working register, mode_i into the mode register, shamt_i into the remaining-count register.
- On accept: go to SHIFT if shamt_i ≠ 0, else to DONE (data passes unchanged).
- In SHIFT, each edge: k = min(STEP, remaining); working register shifted by k per mode; remaining -= k. Go to DONE when the new remaining = 0.
- Fill rules: SLL inserts zeros at the LSB. SRL inserts zeros at the MSB. SRA replicates the captured operand's bit N_BITS-1. ROTL wraps MSBs into the LSBs.
- DONE lasts one cycle: done_o = 1. Next state is IDLE, or the accept target if start_i = 1 (back-to-back).
- busy_o = 1 in SHIFT only; 0 in IDLE and DONE.
- data_o is driven from the working register. During SHIFT it shows intermediate values and must not be consumed. It is valid from DONE until the next accept.
- start_i during SHIFT: ignored, no queuing.
- Inputs other than start_i are don't-care except on the accept edge.

## Timing
- Reset (asynchronous assert, any state): state = IDLE, busy_o = 0, done_o = 0, data_o = 0, remaining = 0. Reset mid-SHIFT aborts with no done_o.
- Latency: done_o is high in the cycle after edge number 1 + ceil(shamt/STEP), where the accept edge is edge 1.
  - shamt = 0: done_o in the cycle right after the accept edge.
  - Worst case: 1 + ceil((N_BITS-1)/STEP) edges.
- Throughput: a new accept is possible in the DONE cycle, so there is no dead cycle between operations.
- busy_o rises in the cycle after the accept edge when shamt ≠ 0. It falls in the same cycle done_o rises.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package shifter_pkg holds:
  - mode encodings MODE_SLL/MODE_SRL/MODE_SRA/MODE_ROTL
  - state enum ST_IDLE/ST_SHIFT/ST_DONE
- Sub-module shift_step is the combinational single stage:
  - inputs: data, mode, amount 0 … STEP, sign bit
  - output: shifted data
  - it is instantiated once and its output is registered by the top-level FSM.

## Test plan
- SLL, STEP=4, data 0x0000_0001, shamt 5: accept → data_o = 0x0000_0020 with done_o high after edge 3; busy_o high for exactly 2 cycles.
- SRA 0x8000_0000 by 4: result 0xF800_0000. SRL of the same value by 4: result 0x0800_0000, done after edge 2.
- ROTL 0x8000_0001 by 1 → 0x0000_0003. SRL 0xF000_0000 by 31 → 0x0000_0001 after edge 9 (ceil(31/4) = 8 shift edges).
- shamt 0, any mode, data 0xDEAD_BEEF: done_o in the cycle after accept, data_o = 0xDEAD_BEEF, busy_o never high.
- start_i held high throughout SHIFT with different data: ignored until DONE. In DONE, the second op is accepted back-to-back and both results are correct.
- reset asserted mid-SHIFT (asynchronous, between edges): outputs go to 0 immediately and no done_o pulse appears. After reset releases, a fresh SLL 0x3 by 2 → 0x0000_000C.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative shifter: operation modes and FSM states.
package shifter_pkg;

  typedef enum logic [1:0] {
    MODE_SLL  = 2'b00,
    MODE_SRL  = 2'b01,
    MODE_SRA  = 2'b10,
    MODE_ROTL = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single stage: shifts data by 0..STEP positions according to mode.
module shift_step
  import shifter_pkg::*;
#(
  parameter int unsigned N_BITS = 32,
  parameter int unsigned STEP   = 4,
  parameter int unsigned AMT_W  = $clog2(STEP + 1)
) (
  input  logic [N_BITS-1:0] data,
  input  mode_e             mode,
  input  logic [AMT_W-1:0]  amount,
  input  logic              sign,
  output logic [N_BITS-1:0] result
);

  logic [2*N_BITS-1:0] ext;

  // Select the shift flavour; the double-width vector gives sign fill and rotate wrap.
  always_comb begin
    result = data;
    ext    = '0;
    unique case (mode)
      MODE_SLL: result = data << amount;
      MODE_SRL: result = data >> amount;
      MODE_SRA: begin
        ext    = {{N_BITS{sign}}, data} >> amount;
        result = ext[N_BITS-1:0];
      end
      MODE_ROTL: begin
        ext    = {data, data} << amount;
        result = ext[2*N_BITS-1:N_BITS];
      end
      default: result = data;
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter moving at most STEP bit positions per clock, with start/busy/done.
module iterative_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned N_BITS = 32,
  parameter int unsigned STEP   = 4,
  localparam int unsigned SHAMT_W = $clog2(N_BITS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [1:0]         mode_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [N_BITS-1:0]  data_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [N_BITS-1:0]  data_o
);

  localparam int unsigned AMT_W = $clog2(STEP + 1);

  state_e               state_q, state_d;
  logic [N_BITS-1:0]    work_q, work_d;
  mode_e                mode_q, mode_d;
  logic [SHAMT_W-1:0]   rem_q, rem_d;
  logic                 sign_q, sign_d;
  logic [AMT_W-1:0]     step_amt;
  logic [N_BITS-1:0]    step_out;
  logic                 accept;

  // Amount moved this cycle: min(STEP, remaining).
  always_comb begin
    if (32'(rem_q) >= STEP) step_amt = AMT_W'(STEP);
    else                    step_amt = AMT_W'(rem_q);
  end

  shift_step #(
    .N_BITS (N_BITS),
    .STEP   (STEP),
    .AMT_W  (AMT_W)
  ) u_shift_step (
    .data   (work_q),
    .mode   (mode_q),
    .amount (step_amt),
    .sign   (sign_q),
    .result (step_out)
  );

  // A new request is taken whenever no shift is in flight, including the DONE cycle.
  assign accept = start_i && (state_q != ST_SHIFT);

  // Next-state logic: capture on accept, iterate in SHIFT, single-cycle DONE.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    sign_d  = sign_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          work_d  = data_i;
          mode_d  = mode_e'(mode_i);
          rem_d   = shamt_i;
          sign_d  = data_i[N_BITS-1];
          state_d = (shamt_i != '0) ? ST_SHIFT : ST_DONE;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_d = step_out;
        rem_d  = rem_q - SHAMT_W'(step_amt);
        if (rem_d == '0) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      mode_q  <= MODE_SLL;
      rem_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      sign_q  <= sign_d;
    end
  end

  assign busy_o = (state_q == ST_SHIFT);
  assign done_o = (state_q == ST_DONE);
  assign data_o = work_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Scoreboard bench for iterative_shifter: stimulus pushes expected results, monitor checks.
module tb_iterative_shifter;

  localparam int N    = 32;
  localparam int STEP = 4;
  localparam int SW   = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_i = 1'b0;
  logic [1:0]    mode_i = '0;
  logic [SW-1:0] shamt_i = '0;
  logic [N-1:0]  data_i = '0;
  logic          busy_o;
  logic          done_o;
  logic [N-1:0]  data_o;

  iterative_shifter #(
    .N_BITS (N),
    .STEP   (STEP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start_i (start_i),
    .mode_i  (mode_i),
    .shamt_i (shamt_i),
    .data_i  (data_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .data_o  (data_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] res;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   busy_cnt = 0;

  // Reference: plain arithmetic on the full shift amount.
  function automatic logic [N-1:0] ref_model(input logic [1:0] m, input int s,
                                             input logic [N-1:0] d);
    logic [2*N-1:0] w;
    logic signed [N-1:0] sd;
    sd = d;
    case (m)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return sd >>> s;
      default: begin
        w = {d, d} << s;
        return w[2*N-1:N];
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done_o pulse must match the head of the scoreboard, on the right cycle.
  always @(negedge clk) begin
    exp_t e;
    if (busy_o) busy_cnt++;
    if (done_o) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done_o=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("result", data_o, e.res);
        check("latency_edge", N'(cyc), N'(e.due));
        check("busy_at_done", N'(busy_o), '0);
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      e = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_done: got no done_o expected done at edge %0d (cycle %0d)",
               e.due, cyc);
    end
  end

  // Issue one operation; with hold set, start_i stays high with junk inputs while busy.
  task automatic issue(input logic [1:0] m, input int s, input logic [N-1:0] d,
                       input bit hold, input bit push);
    int guard = 0;
    int acc_edge;
    @(negedge clk);
    while (busy_o && guard < 200) begin
      if (hold) begin
        start_i = 1'b1;
        data_i  = $urandom;
        mode_i  = 2'($urandom);
        shamt_i = SW'($urandom);
      end
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: got busy_o=1 expected 0 within 200 cycles");
    end
    start_i  = 1'b1;
    mode_i   = m;
    shamt_i  = SW'(s);
    data_i   = d;
    acc_edge = cyc + 1;
    if (push) sb.push_back('{ref_model(m, s, d), acc_edge + (s + STEP - 1) / STEP});
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() > 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #2 reset = 1'b1;
    #2;
    check("reset_data", data_o, '0);
    check("reset_busy", N'(busy_o), '0);
    check("reset_done", N'(done_o), '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // SLL 1 by 5: busy for exactly two cycles.
    busy_cnt = 0;
    issue(2'b00, 5, 32'h0000_0001, 1'b0, 1'b1);
    drain();
    check("sll5_busy_cycles", N'(busy_cnt), 32'd2);

    issue(2'b10, 4, 32'h8000_0000, 1'b0, 1'b1);
    issue(2'b01, 4, 32'h8000_0000, 1'b0, 1'b1);
    issue(2'b11, 1, 32'h8000_0001, 1'b0, 1'b1);
    issue(2'b01, 31, 32'hF000_0000, 1'b0, 1'b1);
    drain();

    // Zero shift in every mode: no busy cycles at all.
    busy_cnt = 0;
    for (int m = 0; m < 4; m++) issue(2'(m), 0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    drain();
    check("shamt0_busy_cycles", N'(busy_cnt), '0);

    // Back-to-back with start_i held through SHIFT carrying junk.
    issue(2'b00, 7, 32'h1234_5678, 1'b0, 1'b1);
    issue(2'b10, 13, 32'h9ABC_DEF0, 1'b1, 1'b1);
    issue(2'b11, 31, 32'h0F0F_00FF, 1'b1, 1'b1);
    drain();

    // Asynchronous reset between edges mid-SHIFT: no done pulse must follow.
    issue(2'b00, 20, 32'h0000_FFFF, 1'b0, 1'b0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("abort_data", data_o, '0);
    check("abort_busy", N'(busy_o), '0);
    check("abort_done", N'(done_o), '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    issue(2'b00, 2, 32'h0000_0003, 1'b0, 1'b1);
    drain();

    // Random traffic, mixing idle gaps and held-start back-to-back issue.
    for (int i = 0; i < 200; i++) begin
      issue(2'($urandom), int'($urandom_range(0, N - 1)), $urandom,
            1'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
